// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types, constants and hazard helper for the pipeline hazard controller
//
// Purpose: FSM state encoding, the x0 register index, the pipeline control vector
// with its four canonical settings, and the load-use hazard detection function.
// Ports: none (package).
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_hold;
    logic idex_hold;
    logic exmem_hold;
    logic noop;
    logic ifid_flush;
  } ctrl_t;

  // Normal flow; ifid_flush is filled in per cycle from the branch/pending flush.
  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_hold: 1'b0, idex_hold: 1'b0,
                                 exmem_hold: 1'b0, noop: 1'b0, ifid_flush: 1'b0};
  // dcache busy: every register keeps its contents.
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_hold: 1'b1, idex_hold: 1'b1,
                                    exmem_hold: 1'b1, noop: 1'b0, ifid_flush: 1'b0};
  // Load-use: ID instruction waits in IF/ID while a bubble enters ID/EX.
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_hold: 1'b1, idex_hold: 1'b0,
                                    exmem_hold: 1'b0, noop: 1'b1, ifid_flush: 1'b0};
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_hold: 1'b0, idex_hold: 1'b0,
                                   exmem_hold: 1'b0, noop: 1'b1, ifid_flush: 1'b1};

  // A load in EX whose destination is a source the ID instruction actually reads.
  // Loads to x0 never create a dependency.
  function automatic logic load_use_hazard(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    return mem_read && (rd != REG_X0) &&
           ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts cycles with inc=1, sticks at all-ones instead of wrapping.
// Ports:
//   clk    in  1  clock
//   rst    in  1  synchronous clear, active-high (has priority over inc)
//   inc    in  1  increment request
//   count  out W  current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hold/bubble/flush generator for the IF/ID, ID/EX and EX/MEM registers
//
// Purpose: detects load-use hazards, freezes the pipe during dcache stalls, remembers a
// branch flush that arrives while frozen, counts stall cycles and runs a stall watchdog.
// Ports:
//   clk_i            in   1      clock
//   rst_i            in   1      synchronous active-high reset
//   IDEX_MemRead_i   in   1      ID/EX MemRead
//   IDEX_RDaddr_i    in   5      ID/EX destination register
//   IFID_RS1addr_i   in   5      ID rs1
//   IFID_RS2addr_i   in   5      ID rs2
//   use_rs1_i        in   1      ID reads rs1
//   use_rs2_i        in   1      ID reads rs2
//   mem_stall_i      in   1      dcache busy
//   branch_flush_i   in   1      taken branch pulse
//   PCWrite_o        out  1      PC may update
//   IFIDhold_o       out  1      IF/ID holds
//   IDEXhold_o       out  1      ID/EX holds
//   EXMEMhold_o      out  1      EX/MEM holds
//   NoOp_o           out  1      bubble into ID/EX
//   IFIDflush_o      out  1      IF/ID loads a NOP
//   lu_stall_cnt_o   out  CNT_W  load-use bubble cycles (saturating)
//   mem_stall_cnt_o  out  CNT_W  mem-stall cycles (saturating)
//   timeout_o        out  1      sticky watchdog flag
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             use_rs1_i,
  input  logic             use_rs2_i,
  input  logic             mem_stall_i,
  input  logic             branch_flush_i,
  output logic             PCWrite_o,
  output logic             IFIDhold_o,
  output logic             IDEXhold_o,
  output logic             EXMEMhold_o,
  output logic             NoOp_o,
  output logic             IFIDflush_o,
  output logic [CNT_W-1:0] lu_stall_cnt_o,
  output logic [CNT_W-1:0] mem_stall_cnt_o,
  output logic             timeout_o
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            pend_q, pend_d;
  logic            lu;
  logic            lu_inc, mem_inc;
  ctrl_t           ctrl;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_clr;

  assign lu = load_use_hazard(IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i,
                              IFID_RS2addr_i, use_rs1_i, use_rs2_i);

  always_ff @(posedge clk_i) begin
    state_q <= state_d;
    pend_q  <= pend_d;
  end

  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = state_q;
    pend_d  = pend_q;
    lu_inc  = 1'b0;
    mem_inc = 1'b0;
    if (rst_i) begin
      ctrl    = CTRL_RESET;
      state_d = RUN;
      pend_d  = 1'b0;
    end else if (mem_stall_i) begin
      // Branch resolved while frozen cannot flush now; replay it on release.
      ctrl    = CTRL_FREEZE;
      state_d = MEM_WAIT;
      mem_inc = 1'b1;
      if (branch_flush_i) begin
        pend_d = 1'b1;
      end
    end else if (lu) begin
      // Branch is dropped here (it re-resolves); a pending flush waits one more cycle.
      ctrl    = CTRL_BUBBLE;
      state_d = RUN;
      lu_inc  = 1'b1;
    end else begin
      ctrl            = CTRL_RUN;
      ctrl.ifid_flush = branch_flush_i | pend_q;
      state_d         = RUN;
      pend_d          = 1'b0;
    end
  end

  assign PCWrite_o   = ctrl.pc_write;
  assign IFIDhold_o  = ctrl.ifid_hold;
  assign IDEXhold_o  = ctrl.idex_hold;
  assign EXMEMhold_o = ctrl.exmem_hold;
  assign NoOp_o      = ctrl.noop;
  assign IFIDflush_o = ctrl.ifid_flush;

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (lu_inc),
    .count (lu_stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (mem_inc),
    .count (mem_stall_cnt_o)
  );

  // Watchdog length = consecutive stalled cycles already seen; any released cycle clears it.
  assign wd_clr = rst_i | ~mem_stall_i;

  sat_counter #(.W(WD_W)) u_wd_cnt (
    .clk   (clk_i),
    .rst   (wd_clr),
    .inc   (mem_stall_i),
    .count (wd_cnt)
  );

  // wd_cnt is nonzero only after a stalled cycle, so the state qualifier never masks a hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_o <= 1'b0;
    end else if ((state_q == MEM_WAIT) && mem_stall_i && (wd_cnt == WD_LAST)) begin
      timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard testbench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_RDaddr_i;
  logic [4:0]       IFID_RS1addr_i;
  logic [4:0]       IFID_RS2addr_i;
  logic             use_rs1_i;
  logic             use_rs2_i;
  logic             mem_stall_i;
  logic             branch_flush_i;
  logic             PCWrite_o;
  logic             IFIDhold_o;
  logic             IDEXhold_o;
  logic             EXMEMhold_o;
  logic             NoOp_o;
  logic             IFIDflush_o;
  logic [CNT_W-1:0] lu_stall_cnt_o;
  logic [CNT_W-1:0] mem_stall_cnt_o;
  logic             timeout_o;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .IDEX_MemRead_i  (IDEX_MemRead_i),
    .IDEX_RDaddr_i   (IDEX_RDaddr_i),
    .IFID_RS1addr_i  (IFID_RS1addr_i),
    .IFID_RS2addr_i  (IFID_RS2addr_i),
    .use_rs1_i       (use_rs1_i),
    .use_rs2_i       (use_rs2_i),
    .mem_stall_i     (mem_stall_i),
    .branch_flush_i  (branch_flush_i),
    .PCWrite_o       (PCWrite_o),
    .IFIDhold_o      (IFIDhold_o),
    .IDEXhold_o      (IDEXhold_o),
    .EXMEMhold_o     (EXMEMhold_o),
    .NoOp_o          (NoOp_o),
    .IFIDflush_o     (IFIDflush_o),
    .lu_stall_cnt_o  (lu_stall_cnt_o),
    .mem_stall_cnt_o (mem_stall_cnt_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected outputs for one cycle: {PCWrite, IFIDhold, IDEXhold, EXMEMhold, NoOp, IFIDflush}.
  typedef struct {
    logic [5:0] ctrl;
    int         lu;
    int         mem;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state, in plain counts.
  bit m_pending;
  int m_lu_cnt, m_mem_cnt, m_stall_run;
  bit m_timeout;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk_i);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("ctrl", int'({PCWrite_o, IFIDhold_o, IDEXhold_o, EXMEMhold_o, NoOp_o, IFIDflush_o}),
              int'(e.ctrl));
        check("lu_stall_cnt", int'(lu_stall_cnt_o), e.lu);
        check("mem_stall_cnt", int'(mem_stall_cnt_o), e.mem);
        check("timeout", int'(timeout_o), int'(e.to));
      end
    end
  end

  // One clock cycle: apply inputs, predict outputs, then advance the model past the edge.
  task automatic cyc(input bit rst, input bit mr, input int rd, input int rs1, input int rs2,
                     input bit u1, input bit u2, input bit stall, input bit bf);
    exp_t e;
    bit   hazard;
    rst_i = rst; IDEX_MemRead_i = mr; IDEX_RDaddr_i = 5'(rd);
    IFID_RS1addr_i = 5'(rs1); IFID_RS2addr_i = 5'(rs2);
    use_rs1_i = u1; use_rs2_i = u2; mem_stall_i = stall; branch_flush_i = bf;
    hazard = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (rst)         e.ctrl = 6'b000011;
    else if (stall)  e.ctrl = 6'b011100;
    else if (hazard) e.ctrl = 6'b010010;
    else             e.ctrl = {5'b10000, bf | m_pending};
    e.lu = m_lu_cnt; e.mem = m_mem_cnt; e.to = m_timeout;
    exp_q.push_back(e);
    @(posedge clk_i);
    if (rst) begin
      m_pending = 0; m_lu_cnt = 0; m_mem_cnt = 0; m_stall_run = 0; m_timeout = 0;
    end else if (stall) begin
      if (bf) m_pending = 1;
      if (m_mem_cnt < CNT_MAX) m_mem_cnt++;
      if (m_stall_run == TIMEOUT - 1) m_timeout = 1;
      m_stall_run++;
    end else begin
      m_stall_run = 0;
      if (hazard) begin
        if (m_lu_cnt < CNT_MAX) m_lu_cnt++;
      end else begin
        m_pending = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input bit bf);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, bf);
  endtask

  initial begin
    rst_i = 1; IDEX_MemRead_i = 0; IDEX_RDaddr_i = 0; IFID_RS1addr_i = 0; IFID_RS2addr_i = 0;
    use_rs1_i = 0; use_rs2_i = 0; mem_stall_i = 0; branch_flush_i = 0;
    m_pending = 0; m_lu_cnt = 0; m_mem_cnt = 0; m_stall_run = 0; m_timeout = 0;
    @(posedge clk_i);
    #1;

    // Reset held two cycles.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load-use on rs1, then the same pattern with rd = x0.
    cyc(0, 1, 5, 5, 0, 1, 0, 0, 0);
    idle(0);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 7, 3, 7, 0, 1, 0, 0);
    cyc(0, 1, 7, 3, 7, 1, 0, 0, 0);

    // Three-cycle mem stall with a branch in the second cycle; flush lands in cycle 4.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0);
    idle(0);

    // Pending flush delayed by a load-use in the first released cycle.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 1, 9, 9, 0, 1, 0, 0, 0);
    idle(0);
    idle(0);

    // Load-use and mem stall together: freeze wins.
    cyc(0, 1, 5, 5, 0, 1, 0, 1, 0);
    idle(0);

    // Watchdog: four stalled cycles, sticky after release until reset.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) idle(0);
    // Three stalls after a fresh reset must not trip it.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0);
    idle(0);

    // Five load-use cycles saturate a 2-bit counter.
    for (int i = 0; i < 5; i++) cyc(0, 1, 4, 0, 4, 0, 1, 0, 0);
    idle(0);

    // Reset mid-stall with a pending flush: next cycle is RUN with no flush.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0);
    idle(0);

    // Randomized traffic with small register indices to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 59) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk_i);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
